// File: rtl/aes_feedback_cipher.sv
// Byte-serial feedback stream cipher: out = in ^ S(fb), where fb chains on the ciphertext byte.
// A single datapath serves encrypt and decrypt; enc_dec only picks which byte is the ciphertext.
module aes_feedback_cipher (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic [7:0] in_msg,
  input  logic       new_msg,
  input  logic       enc_dec,
  input  logic       in_valid,
  output logic [7:0] out_msg,
  output logic       out_ready
);

  // AES forward S-box, indexed [row*16 + col]
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] r_fb;
  logic [7:0] r_out_msg;
  logic       r_out_ready;
  logic [7:0] w_keystream;
  logic [7:0] w_result;
  logic [7:0] w_fb_next;

  assign w_keystream = SBOX[r_fb];
  assign w_result    = in_msg ^ w_keystream;
  // fb always follows the ciphertext byte: our output when encrypting, our input when decrypting
  assign w_fb_next   = enc_dec ? w_result : in_msg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fb        <= 8'h00;
      r_out_msg   <= 8'h00;
      r_out_ready <= 1'b0;
    end else if (new_msg) begin
      r_fb        <= key;
      r_out_msg   <= 8'h00;
      r_out_ready <= 1'b0;
    end else if (in_valid) begin
      r_fb        <= w_fb_next;
      r_out_msg   <= w_result;
      r_out_ready <= 1'b1;
    end else begin
      r_out_ready <= 1'b0;
    end
  end

  assign out_msg   = r_out_msg;
  assign out_ready = r_out_ready;

endmodule

// File: tb/tb_aes_feedback_cipher.sv
// Directed bench for aes_feedback_cipher: hand-computed vectors plus an encrypt/decrypt round trip.
module tb_aes_feedback_cipher;

  logic       clk;
  logic       rst;
  logic [7:0] key;
  logic [7:0] in_msg;
  logic       new_msg;
  logic       enc_dec;
  logic       in_valid;
  logic [7:0] out_msg;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pt [10];
  logic [7:0] ct [10];

  aes_feedback_cipher dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .in_msg   (in_msg),
    .new_msg  (new_msg),
    .enc_dec  (enc_dec),
    .in_valid (in_valid),
    .out_msg  (out_msg),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, land 1ns after it, then drop the strobes.
  task automatic cyc(input logic nm, input logic iv, input logic ed, input logic [7:0] d);
    new_msg  = nm;
    in_valid = iv;
    enc_dec  = ed;
    in_msg   = d;
    @(posedge clk);
    #1;
    new_msg  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic byte_chk(input string tag, input logic ed, input logic [7:0] d, input logic [7:0] exp);
    cyc(1'b0, 1'b1, ed, d);
    chk({tag, "_msg"}, out_msg, exp);
    chk({tag, "_rdy"}, {7'd0, out_ready}, 8'h01);
  endtask

  initial begin
    rst = 1'b0; key = 8'h00; in_msg = 8'h00;
    new_msg = 1'b0; enc_dec = 1'b1; in_valid = 1'b0;
    #2;
    chk("reset_msg", out_msg, 8'h00);
    chk("reset_rdy", {7'd0, out_ready}, 8'h00);
    @(negedge clk); rst = 1'b1;

    // Encrypt key A5: 00,00,01 -> 06, 6F, 01^S(6F)=A9
    key = 8'hA5;
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("newmsg_rdy", {7'd0, out_ready}, 8'h00);
    byte_chk("enc0", 1'b1, 8'h00, 8'h06);
    byte_chk("enc1", 1'b1, 8'h00, 8'h6F);
    byte_chk("enc2", 1'b1, 8'h01, 8'hA9);
    // Idle gaps: output held, pulse low, chain intact (next P=00 -> S(A9)=D3)
    cyc(1'b0, 1'b0, 1'b1, 8'h55);
    chk("idle1_rdy", {7'd0, out_ready}, 8'h00);
    chk("idle1_hold", out_msg, 8'hA9);
    cyc(1'b0, 1'b0, 1'b1, 8'h77);
    chk("idle2_hold", out_msg, 8'hA9);
    byte_chk("enc3", 1'b1, 8'h00, 8'hD3);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pulse_drop", {7'd0, out_ready}, 8'h00);

    // Decrypt key A5: 06,6F -> 00,00; fb now 6F so C=00 -> S(6F)=A8
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("newmsg_clr", out_msg, 8'h00);
    byte_chk("dec0", 1'b0, 8'h06, 8'h00);
    byte_chk("dec1", 1'b0, 8'h6F, 8'h00);
    byte_chk("dec2", 1'b0, 8'h00, 8'hA8);

    // Mixed direction per byte, key 00: enc 00 -> 63 (fb=63); dec 00 -> S(63)=FB (fb=00); enc 00 -> 63
    key = 8'h00;
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    byte_chk("mix_e0", 1'b1, 8'h00, 8'h63);
    byte_chk("mix_d1", 1'b0, 8'h00, 8'hFB);
    byte_chk("mix_e2", 1'b1, 8'h00, 8'h63);

    // new_msg and in_valid together: byte 11 dropped, fb=A5
    key = 8'hA5;
    cyc(1'b1, 1'b1, 1'b1, 8'h11);
    chk("wrong_rdy", {7'd0, out_ready}, 8'h00);
    chk("wrong_msg", out_msg, 8'h00);
    byte_chk("wrong_p1", 1'b1, 8'h00, 8'h06);
    byte_chk("wrong_p2", 1'b1, 8'h00, 8'h6F);
    // Decrypting the delivered stream yields P[1..] (00,00), never the dropped 11
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    byte_chk("wrong_d1", 1'b0, 8'h06, 8'h00);
    byte_chk("wrong_d2", 1'b0, 8'h6F, 8'h00);

    // Round trip of 10 random bytes, key 3C
    for (int i = 0; i < 10; i++) pt[i] = 8'($urandom_range(0, 255));
    key = 8'h3C;
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, pt[i]);
      ct[i] = out_msg;
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ct[i]);
      chk($sformatf("rt%0d", i), out_msg, pt[i]);
    end

    // Reset mid-message after 3 bytes, then chain from fb=00 without new_msg
    key = 8'hA5;
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    byte_chk("pre_rst0", 1'b1, 8'h00, 8'h06);
    byte_chk("pre_rst1", 1'b1, 8'h00, 8'h6F);
    byte_chk("pre_rst2", 1'b1, 8'h01, 8'hA9);
    #2 rst = 1'b0;
    #1;
    chk("midrst_msg", out_msg, 8'h00);
    chk("midrst_rdy", {7'd0, out_ready}, 8'h00);
    @(negedge clk); rst = 1'b1;
    byte_chk("post_rst0", 1'b1, 8'h00, 8'h63);
    byte_chk("post_rst1", 1'b1, 8'h00, 8'hFB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_feedback_cipher.md
# aes_feedback_cipher

Byte-serial feedback stream cipher built around the AES forward S-box (SubBytes). Each input byte is XORed with the S-box image of the previous ciphertext byte; the 8-bit key seeds the chain. One engine handles both encryption and decryption, selected per byte. It sits between a byte-wide message source and sink, one byte per valid strobe, with a one-cycle registered result.

## Interface
- No parameters; all data paths are 8 bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- key  input  8  chain seed; sampled only on a new_msg cycle.
- in_msg  input  8  plaintext (encrypt) or ciphertext (decrypt) byte; sampled when in_valid=1.
- new_msg  input  1  start of message; loads key into the feedback register.
- enc_dec  input  1  1 = encrypt, 0 = decrypt; sampled with each valid byte.
- in_valid  input  1  in_msg holds a byte to process this cycle.
- out_msg  output  8  registered result byte.
- out_ready  output  1  one-cycle pulse: out_msg holds a new result.

## Operation
- S(x) is the standard AES forward S-box, a 256-entry constant table. Reference values: S(00)=63, S(01)=7C, S(06)=6F, S(53)=ED, S(A5)=06.
- Internal state is the 8-bit feedback register fb.
- Encrypt: C[i] = P[i] ^ S(fb), then fb <= C[i]. fb starts as key, so C[0] = P[0] ^ S(K).
- Decrypt: P[i] = C[i] ^ S(fb), then fb <= C[i], which is the input byte. P[0] = C[0] ^ S(K).
- fb always takes the ciphertext byte: the result when encrypting, the input when decrypting.
- Per rising edge, first match wins:
  1. new_msg=1: fb <= key, out_msg <= 00, out_ready <= 0. in_valid and in_msg are ignored this cycle, so that byte is dropped and produces no output.
  2. in_valid=1: out_msg <= in_msg ^ S(fb); fb <= ciphertext byte as above; out_ready <= 1.
  3. Otherwise: out_ready <= 0; out_msg and fb hold.
- Correct use asserts new_msg for at least one edge before the first in_valid.
- enc_dec may change between bytes; each byte uses the enc_dec value sampled with it. fb selection follows that sampled value.
- in_valid with no prior new_msg since reset chains from fb=00.

## Timing
- Reset (rst=0, asynchronous, immediate): out_msg=00, out_ready=0, fb=00. This also applies mid-message; the chain is lost and needs a new new_msg.
- Latency is 1 cycle. A byte sampled at edge N appears on out_msg and out_ready after edge N and stays valid until edge N+1.
- out_msg holds its last value until the next valid byte, new_msg or reset.
- Back-to-back in_valid runs at full throughput: one byte per clock, each chaining on the previous ciphertext.
- S-box lookup and XOR are combinational from registered fb and in_msg. No multicycle paths.

## Test plan
- Reset: hold rst=0 -> out_msg=00, out_ready=0 immediately, with no clock edge needed.
- Encrypt: key=A5, new_msg for one edge, then in_valid with P=00, 00, 01 on consecutive edges, enc_dec=1 -> outputs 06, 6F, then 01^S(6F). Each output has a one-cycle out_ready pulse.
- Decrypt: key=A5, new_msg, then C=06, 6F with enc_dec=0 -> outputs 00, 00. Also round-trip 10 random bytes through encrypt then decrypt -> original bytes recovered.
- Wrong use (new_msg and in_valid on the same edge): key=A5, in_msg=11 -> out_ready=0, out_msg=00, fb=A5. Next byte P=00 -> 06 (= 00 ^ S(A5)). The following decryption of that stream reproduces P[1..] but not P[0].
- Idle gaps and holds: insert idle cycles between bytes -> out_ready low in idle cycles, out_msg held, chain unchanged.
- Reset mid-message after 3 bytes, then in_valid with P=00 and no new_msg -> output 63 (00 ^ S(00)).
